// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port ram arbiter.
// State encoding, port ids and the strobe-hold counter type.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    // Wide enough for the full 1..15 hold-time range.
    localparam int WAIT_W = 4;
    typedef logic [WAIT_W-1:0] wait_cnt_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant from req, with a registered
// last-grant pointer that advances only when en is high and something is granted.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    logic last;

    // On a tie the port that was not served last wins.
    always_comb begin
        grant = req;
        if (req[0] && req[1]) begin
            grant = (last == PORT_DATA) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            last <= PORT_DATA;
        end else if (en && (grant != 2'b00)) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port ram between instruction fetch (port 0) and the
// load/store path (port 1); holds ram strobes stable for WAIT_CYCLES cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    output logic [31:0] p0_rdata,
    output logic        p0_done,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic [31:0] p1_rdata,
    output logic        p1_done,
    output logic        p1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout,
    output state_t      dbg_state
);

    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
    localparam wait_cnt_t   LAST_CNT = wait_cnt_t'(WAIT_CYCLES - 1);

    state_t      state;
    wait_cnt_t   cnt;
    logic        gnt_port;
    logic        lat_we;
    logic [1:0]  grant;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic        sel_oor;

    rr_arbiter2 u_rr (
        .clk   (clk),
        .clr   (clr),
        .req   ({p1_req, p0_req}),
        .en    (state == IDLE),
        .grant (grant)
    );

    // Full 32-bit compare: high address bits are never dropped.
    assign sel_addr  = grant[1] ? p1_addr : p0_addr;
    assign sel_we    = grant[1] & p1_we;
    assign sel_oor   = (sel_addr >= DEPTH_W);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt_port  <= PORT_FETCH;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            p0_done   <= 1'b0;
            p1_done   <= 1'b0;
            p1_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        gnt_port <= grant[1];
                        lat_we   <= sel_we;
                        mem_addr <= sel_addr;
                        mem_din  <= grant[1] ? p1_wdata : '0;
                        cnt      <= '0;
                        if (sel_oor) begin
                            // Out of range: no ram cycle, report straight away.
                            state <= DONE;
                            if (grant[1]) begin
                                p1_done <= 1'b1;
                                p1_err  <= 1'b1;
                            end else begin
                                p0_done  <= 1'b1;
                                p0_rdata <= '0;
                            end
                        end else begin
                            state     <= ACCESS;
                            mem_read  <= ~sel_we;
                            mem_write <= sel_we;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == LAST_CNT) begin
                        state     <= DONE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (gnt_port == PORT_DATA) begin
                            p1_done <= 1'b1;
                            if (!lat_we) begin
                                p1_rdata <= mem_dout;
                            end
                        end else begin
                            p0_done  <= 1'b1;
                            p0_rdata <= mem_dout;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    p0_done <= 1'b0;
                    p1_done <= 1'b0;
                    p1_err  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed requests with hand-computed responses,
// checked by per-instance scoreboards; instances built with WAIT_CYCLES 1 and 3.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic mon_en = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [33:0] exp_q[$];
    logic [33:0] exp3_q[$];

    // WAIT_CYCLES = 1 instance
    logic        p0_req, p0_done, p1_req, p1_we, p1_done, p1_err, mem_read, mem_write;
    logic [31:0] p0_addr, p0_rdata, p1_addr, p1_wdata, p1_rdata, mem_addr, mem_din, mem_dout;
    state_t      dbg_state;
    logic [31:0] ram1 [0:511];

    // WAIT_CYCLES = 3 instance
    logic        q_p0_req, q_p0_done, q_p1_req, q_p1_we, q_p1_done, q_p1_err, q_mem_read, q_mem_write;
    logic [31:0] q_p0_addr, q_p0_rdata, q_p1_addr, q_p1_wdata, q_p1_rdata, q_mem_addr, q_mem_din, q_mem_dout;
    state_t      q_dbg_state;
    logic [31:0] ram3 [0:511];

    mem_arbiter #(.DEPTH(512), .WAIT_CYCLES(1)) dut (
        .clk(clk), .clr(clr),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_rdata(p0_rdata), .p0_done(p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_done(p1_done), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read), .mem_write(mem_write),
        .mem_dout(mem_dout), .dbg_state(dbg_state)
    );

    mem_arbiter #(.DEPTH(512), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .clr(clr),
        .p0_req(q_p0_req), .p0_addr(q_p0_addr), .p0_rdata(q_p0_rdata), .p0_done(q_p0_done),
        .p1_req(q_p1_req), .p1_we(q_p1_we), .p1_addr(q_p1_addr), .p1_wdata(q_p1_wdata),
        .p1_rdata(q_p1_rdata), .p1_done(q_p1_done), .p1_err(q_p1_err),
        .mem_addr(q_mem_addr), .mem_din(q_mem_din), .mem_read(q_mem_read), .mem_write(q_mem_write),
        .mem_dout(q_mem_dout), .dbg_state(q_dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    // level-sensitive ram models
    assign mem_dout   = ram1[mem_addr[8:0]];
    assign q_mem_dout = ram3[q_mem_addr[8:0]];

    always @(posedge clk) begin
        if (mem_write) ram1[mem_addr[8:0]] <= mem_din;
        if (q_mem_write) ram3[q_mem_addr[8:0]] <= q_mem_din;
    end

    function automatic logic [33:0] mk(input logic port, input logic err, input logic [31:0] d);
        return {port, err, d};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        logic [33:0] e;
        if (mon_en) begin
            check("strobe_excl", 64'(mem_read & mem_write), 64'd0);
            if (p1_err && !p1_done) check("err_without_done", 64'd1, 64'd0);
            if (p0_done || p1_done) begin
                if (p0_done && p1_done) check("dual_done", 64'd1, 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp", {30'd0, p1_done, p1_err, (p1_done ? p1_rdata : p0_rdata)}, {30'd0, e});
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [33:0] e;
        if (mon_en) begin
            check("strobe_excl_w3", 64'(q_mem_read & q_mem_write), 64'd0);
            if (q_p0_done || q_p1_done) begin
                if (exp3_q.size() == 0) begin
                    check("unexpected_done_w3", 64'd1, 64'd0);
                end else begin
                    e = exp3_q.pop_front();
                    check("resp_w3", {30'd0, q_p1_done, q_p1_err, (q_p1_done ? q_p1_rdata : q_p0_rdata)}, {30'd0, e});
                end
            end
        end
    end

    // driver: one request on the WAIT_CYCLES=1 instance
    task automatic do_req(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [33:0] exp,
                          input int exp_lat, input int exp_rd, input int exp_wr);
        int  k = 0;
        int  rd = 0;
        int  wr = 0;
        bit  seen = 0;
        exp_q.push_back(exp);
        @(negedge clk);
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = 1'b1; p0_addr = addr;
        end
        while (k < 50 && !seen) begin
            @(negedge clk);
            k++;
            if (mem_read) rd++;
            if (mem_write) begin
                wr++;
                check("mem_din", mem_din, wdata);
            end
            if (mem_read || mem_write) check("mem_addr", mem_addr, addr);
            seen = port ? p1_done : p0_done;
        end
        check("done_seen", 64'(seen), 64'd1);
        check("latency", 64'(k), 64'(exp_lat));
        check("read_cycles", 64'(rd), 64'(exp_rd));
        check("write_cycles", 64'(wr), 64'(exp_wr));
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        int rd;
        for (int i = 0; i < 512; i++) begin
            ram1[i] = '0;
            ram3[i] = '0;
        end
        ram1[10] = 32'h0A0A; ram1[20] = 32'h1414; ram1[43] = 32'd2;
        ram1[200] = 32'h77;  ram1[511] = 32'h1FF; ram3[95] = 32'd13;

        p0_req = 0; p0_addr = 0; p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        q_p0_req = 0; q_p0_addr = 0; q_p1_req = 0; q_p1_we = 0; q_p1_addr = 0; q_p1_wdata = 0;

        clr = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_p0_rdata", p0_rdata, 0);
        check("rst_p1_rdata", p1_rdata, 0);
        check("rst_done", {p0_done, p1_done, p1_err}, 0);
        check("rst_strobes", {mem_read, mem_write}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        check("rst_state_w3", 64'(q_dbg_state), 64'(IDLE));
        clr = 1'b0;
        mon_en = 1'b1;

        // both ports held: p0 wins first tie, then strict alternation
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0A0A));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h1414));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0A0A));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h1414));
        p0_addr = 32'd10; p1_addr = 32'd20; p1_we = 1'b0;
        @(negedge clk);
        p0_req = 1'b1; p1_req = 1'b1;
        n = 0; k = 0;
        while (k < 60 && n < 4) begin
            @(negedge clk);
            k++;
            if (p0_done || p1_done) n++;
        end
        check("arb_done_count", 64'(n), 64'd4);
        check("arb_cycles", 64'(k), 64'd11);
        p0_req = 1'b0; p1_req = 1'b0;

        do_req(1'b1, 1'b0, 32'd43, 32'd0, mk(1'b1, 1'b0, 32'd2), 2, 1, 0);
        do_req(1'b1, 1'b1, 32'd87, 32'h1234, mk(1'b1, 1'b0, 32'd2), 2, 0, 1);
        do_req(1'b0, 1'b0, 32'd87, 32'd0, mk(1'b0, 1'b0, 32'h1234), 2, 1, 0);
        do_req(1'b1, 1'b0, 32'd512, 32'd0, mk(1'b1, 1'b1, 32'd2), 1, 0, 0);
        do_req(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hBEEF, mk(1'b1, 1'b1, 32'd2), 1, 0, 0);
        do_req(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0, mk(1'b1, 1'b1, 32'd2), 1, 0, 0);
        do_req(1'b0, 1'b0, 32'd600, 32'd0, mk(1'b0, 1'b0, 32'd0), 1, 0, 0);
        do_req(1'b0, 1'b0, 32'd43, 32'd0, mk(1'b0, 1'b0, 32'd2), 2, 1, 0);
        do_req(1'b0, 1'b0, 32'd1067, 32'd0, mk(1'b0, 1'b0, 32'd0), 1, 0, 0);

        // reset in the middle of a p1 write
        @(negedge clk);
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'd200; p1_wdata = 32'h77;
        @(negedge clk);
        check("abort_in_access", 64'(dbg_state), 64'(ACCESS));
        check("abort_write_on", 64'(mem_write), 64'd1);
        clr = 1'b1; p1_req = 1'b0;
        @(negedge clk);
        check("abort_state", 64'(dbg_state), 64'(IDLE));
        check("abort_strobes", {mem_read, mem_write}, 0);
        check("abort_no_done", 64'(p1_done), 64'd0);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        do_req(1'b1, 1'b0, 32'd200, 32'd0, mk(1'b1, 1'b0, 32'h77), 2, 1, 0);
        do_req(1'b1, 1'b0, 32'd511, 32'd0, mk(1'b1, 1'b0, 32'h1FF), 2, 1, 0);

        // WAIT_CYCLES = 3: strobe and address held three cycles
        exp3_q.push_back(mk(1'b0, 1'b0, 32'd13));
        q_p0_addr = 32'd95;
        @(negedge clk);
        q_p0_req = 1'b1;
        k = 0; rd = 0;
        while (k < 50 && !q_p0_done) begin
            @(negedge clk);
            k++;
            if (q_mem_read) begin
                rd++;
                check("w3_mem_addr", q_mem_addr, 32'd95);
            end
        end
        check("w3_done_seen", 64'(q_p0_done), 64'd1);
        check("w3_latency", 64'(k), 64'd4);
        check("w3_read_cycles", 64'(rd), 64'd3);
        q_p0_req = 1'b0;

        repeat (5) @(negedge clk);
        check("queue_drain", 64'(exp_q.size() + exp3_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
